// File: rtl/sha256_pkg.sv
// Shared SHA-256 scheduler constants, word type and FSM state encoding.
// Imported by the sigma helper and the message scheduler top.
package sha256_pkg;

    localparam int WK_LENGTH = 64;
    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int WIN_N     = BLOCK_W / WORD_W;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small sigma: SIGMA1=0 gives sigma0, SIGMA1=1 gives sigma1.
// Ports: x (input word), y (sigma of x).
module sha256_sigma
    import sha256_pkg::*;
#(
    parameter bit SIGMA1 = 1'b0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    generate
        if (SIGMA1) begin : g_s1
            assign y = {x[16:0], x[31:17]}
                     ^ {x[18:0], x[31:19]}
                     ^ {10'b0, x[31:10]};
        end else begin : g_s0
            assign y = {x[6:0], x[31:7]}
                     ^ {x[17:0], x[31:18]}
                     ^ {3'b0, x[31:3]};
        end
    endgenerate

endmodule

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: takes a 512-bit block, streams W[0..WK_LENGTH-1].
// Ports: clock/reset, block_valid/ready/data in, w_valid/ready/word + index out, complete pulse.
module sha256_msg_scheduler
    import sha256_pkg::*;
#(
    parameter int WK_LENGTH = sha256_pkg::WK_LENGTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         block_valid,
    output logic                         block_ready,
    input  logic [BLOCK_W-1:0]           block_data,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic [WORD_W-1:0]            w_word,
    output logic [$clog2(WK_LENGTH)-1:0] wk_vector_index,
    output logic                         wk_index_complete
);

    localparam int IDX_W = $clog2(WK_LENGTH);
    localparam logic [IDX_W-1:0] T_LAST = IDX_W'(WK_LENGTH - 1);

    sched_state_e state_q;
    sched_state_e state_d;

    logic [WORD_W-1:0] win_q [WIN_N];
    logic [IDX_W-1:0]  t_q;

    logic              load;
    logic              xfer;
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] w_new;

    // win_q[0] is W[t]; the tap positions give W[t+16].
    sha256_sigma #(.SIGMA1(1'b0)) u_s0 (.x(win_q[1]),  .y(s0));
    sha256_sigma #(.SIGMA1(1'b1)) u_s1 (.x(win_q[14]), .y(s1));

    assign w_new = s1 + win_q[9] + s0 + win_q[0];

    always_comb begin
        state_d           = state_q;
        load              = 1'b0;
        block_ready       = 1'b0;
        w_valid           = 1'b0;
        wk_index_complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                block_ready = 1'b1;
                if (block_valid) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                w_valid = 1'b1;
                if (w_ready && (t_q == T_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wk_index_complete = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign xfer            = w_valid & w_ready;
    assign w_word          = win_q[0];
    assign wk_vector_index = t_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_q <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
        end else if (load) begin
            t_q <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= block_data[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
        end else if (xfer) begin
            // Hold t on the last word so it never wraps inside a block.
            if (t_q != T_LAST) begin
                t_q <= t_q + IDX_W'(1);
            end
            for (int i = 0; i < WIN_N - 1; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[WIN_N-1] <= w_new;
        end
    end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Directed bench for sha256_msg_scheduler.
// Drives/samples on the falling edge; expected words from a plain array model.
module tb_sha256_msg_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_word;
    logic [5:0]   wk_vector_index;
    logic         wk_index_complete;

    sha256_msg_scheduler #(.WK_LENGTH(64)) dut (
        .clock             (clock),
        .reset             (reset),
        .block_valid       (block_valid),
        .block_ready       (block_ready),
        .block_data        (block_data),
        .w_valid           (w_valid),
        .w_ready           (w_ready),
        .w_word            (w_word),
        .wk_vector_index   (wk_vector_index),
        .wk_index_complete (wk_index_complete)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  exp_w  [64];
    logic [31:0]  hand_w [4];
    logic [511:0] abc_blk;
    logic [511:0] b_blk;
    int           cyc_cnt = 0;
    int           acc_q [$];

    always @(posedge clock) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!reset && block_valid && block_ready) acc_q.push_back(cyc_cnt);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = m_s1(exp_w[i-2]) + exp_w[i-7]
                     + m_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // Called on a falling edge in IDLE; returns on the first EMIT falling edge.
    task automatic send_block(input logic [511:0] blk);
        chk("ready_idle", 32'(block_ready), 32'd1);
        block_valid = 1'b1;
        block_data  = blk;
        @(negedge clock);
        block_valid = 1'b0;
        chk("first_valid", 32'(w_valid), 32'd1);
        chk("first_idx", 32'(wk_vector_index), 32'd0);
    endtask

    // mode 0: ready=1; mode 1: ready pattern 1,0,0,1; mode 2: ready=1 plus
    // a competing block_valid during EMIT. Stops after stop_at transfers.
    task automatic drain(input int mode, input int stop_at, input bit hand_en);
        int n = 0;
        int vcyc = 0;
        int pulses = 0;
        int k = 0;
        bit held = 1'b0;
        logic [31:0] hw = '0;
        logic [5:0]  hi = '0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (n < stop_at && k < 400) begin
            w_ready = (mode == 1) ? pat[k % 4] : 1'b1;
            if (mode == 2) begin
                block_valid = (n >= 5 && n < 10);
                block_data  = ~abc_blk;
            end
            if (wk_index_complete) pulses++;
            if (held) begin
                chk("hold_word", w_word, hw);
                chk("hold_idx", 32'(wk_vector_index), 32'(hi));
                held = 1'b0;
            end
            if (w_valid) begin
                vcyc++;
                if (w_ready) begin
                    chk($sformatf("w%0d", n), w_word, exp_w[n]);
                    chk($sformatf("idx%0d", n), 32'(wk_vector_index), 32'(n));
                    if (hand_en && n >= 16 && n < 20)
                        chk($sformatf("hand_w%0d", n), w_word, hand_w[n-16]);
                    n++;
                end else begin
                    held = 1'b1;
                    hw   = w_word;
                    hi   = wk_vector_index;
                end
            end
            @(negedge clock);
            k++;
        end
        w_ready = 1'b0;
        if (mode == 2) block_valid = 1'b0;
        chk("drain_count", 32'(n), 32'(stop_at));
        chk("no_early_pulse", 32'(pulses), 32'd0);
        if (stop_at == 64) begin
            if (mode != 1) chk("valid_cycles", 32'(vcyc), 32'd64);
            chk("done_pulse", 32'(wk_index_complete), 32'd1);
            chk("done_valid", 32'(w_valid), 32'd0);
            @(negedge clock);
            chk("pulse_end", 32'(wk_index_complete), 32'd0);
            chk("ready_back", 32'(block_ready), 32'd1);
        end
    endtask

    initial begin
        int n_acc;
        int qn;
        hand_w  = '{32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6};
        abc_blk = {32'h61626380, 448'b0, 32'h00000018};
        for (int i = 0; i < 16; i++)
            b_blk[511-32*i -: 32] = 32'h9E3779B9 * (i + 1);
        reset       = 1'b1;
        block_valid = 1'b0;
        w_ready     = 1'b0;
        block_data  = '0;
        #1;
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_word", w_word, 32'd0);
        chk("rst_idx", 32'(wk_vector_index), 32'd0);
        chk("rst_cmpl", 32'(wk_index_complete), 32'd0);
        chk("rst_ready", 32'(block_ready), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        build_model(abc_blk);
        send_block(abc_blk);
        drain(0, 64, 1'b1);

        build_model('0);
        send_block('0);
        drain(0, 64, 1'b0);

        build_model(abc_blk);
        send_block(abc_blk);
        drain(1, 64, 1'b1);

        n_acc = acc_q.size();
        build_model(abc_blk);
        send_block(abc_blk);
        drain(2, 64, 1'b1);
        chk("emit_ignore", 32'(acc_q.size()), 32'(n_acc + 1));

        build_model(abc_blk);
        send_block(abc_blk);
        drain(0, 20, 1'b0);
        chk("pre_rst_idx", 32'(wk_vector_index), 32'd20);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(w_valid), 32'd0);
        chk("arst_word", w_word, 32'd0);
        chk("arst_ready", 32'(block_ready), 32'd1);
        chk("arst_cmpl", 32'(wk_index_complete), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_valid", 32'(w_valid), 32'd0);
            chk("post_rst_cmpl", 32'(wk_index_complete), 32'd0);
        end
        send_block(abc_blk);
        drain(0, 64, 1'b1);

        n_acc = acc_q.size();
        build_model(abc_blk);
        block_valid = 1'b1;
        block_data  = abc_blk;
        @(negedge clock);
        chk("b2b_first_valid", 32'(w_valid), 32'd1);
        block_data = b_blk;
        drain(0, 64, 1'b1);
        build_model(b_blk);
        @(negedge clock);
        block_valid = 1'b0;
        chk("b2b_second_valid", 32'(w_valid), 32'd1);
        drain(0, 64, 1'b0);
        qn = acc_q.size();
        chk("b2b_accepts", 32'(qn - n_acc), 32'd2);
        if (qn >= 2)
            chk("b2b_period", 32'(acc_q[qn-1] - acc_q[qn-2]), 32'd66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
